// File: rtl/m3_result_bcd.sv
// Captures a signed result on a rising ready level and converts its magnitude to packed BCD by double dabble, one bit per clock.
// Optional macro M3_LEADING_ZERO_BLANK_EN writes leading zero digits as 4'hF (digit 0 is never blanked).
module m3_result_bcd #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      i_result,
  input  logic                  i_result_ready,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic                  o_sign,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic [3:0]            o_ndigits,
  output logic                  o_overrun
);

  localparam int              CW   = $clog2(WIDTH + 1);
  localparam int              BW   = 4 * DIGITS;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH, DONE} state_t;

  state_t           state_q;
  logic             rdy_q;
  logic             sign_q;
  logic [WIDTH-1:0] mag_q;
  logic [WIDTH-1:0] mag_d;
  logic [BW-1:0]    scr_q;
  logic [BW-1:0]    scr_d;
  logic [BW-1:0]    bcd_fmt;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       ndig;
  logic             capture;

  logic             busy_q;
  logic             valid_q;
  logic             osign_q;
  logic [BW-1:0]    bcd_q;
  logic [3:0]       nd_q;
  logic             ovr_q;

  assign capture = i_result_ready & ~rdy_q;
  // Unsigned negate so the most negative input maps to 2^(WIDTH-1).
  assign mag_d   = i_result[WIDTH-1] ? (~i_result + {{(WIDTH-1){1'b0}}, 1'b1}) : i_result;

  always_comb begin
    scr_d = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        scr_d[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    ndig = 4'd1;
    for (int i = 1; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] != 4'd0) begin
        ndig = 4'(i + 1);
      end
    end
  end

  always_comb begin
    bcd_fmt = scr_q;
`ifdef M3_LEADING_ZERO_BLANK_EN
    for (int i = 1; i < DIGITS; i++) begin
      if (i >= int'(ndig)) begin
        bcd_fmt[4*i +: 4] = 4'hF;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      osign_q <= 1'b0;
      bcd_q   <= '0;
      nd_q    <= 4'd0;
      ovr_q   <= 1'b0;
    end else begin
      rdy_q <= i_result_ready;
      ovr_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (capture) begin
            sign_q  <= i_result[WIDTH-1];
            mag_q   <= mag_d;
            scr_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (capture) ovr_q <= 1'b1;
          {scr_q, mag_q} <= {scr_d, mag_q} << 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= FINISH;
        end
        FINISH: begin
          // A capture here lands on the completing edge and is dropped.
          if (capture) ovr_q <= 1'b1;
          bcd_q   <= bcd_fmt;
          nd_q    <= ndig;
          osign_q <= sign_q & (|scr_q);
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy    = busy_q;
  assign o_valid   = valid_q;
  assign o_sign    = osign_q;
  assign o_bcd     = bcd_q;
  assign o_ndigits = nd_q;
  assign o_overrun = ovr_q;

endmodule

// File: tb/tb_m3_result_bcd.sv
// Bench for m3_result_bcd: vector table plus overrun, finish-edge overrun and reset-abort sequences.
module tb_m3_result_bcd;
  localparam int WIDTH  = 32;
  localparam int DIGITS = 10;
  localparam int LAT    = WIDTH + 1;

  typedef struct {
    logic [31:0] res;
    logic        sgn;
    logic [39:0] bcd;
    logic [3:0]  nd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] i_result = '0;
  logic        i_result_ready = 1'b0;
  logic        o_busy, o_valid, o_sign, o_overrun;
  logic [39:0] o_bcd;
  logic [3:0]  o_ndigits;

  int   checks = 0;
  int   passed = 0;
  vec_t sb[$];
  vec_t mon_e;
  logic valid_prev = 1'b0;

  m3_result_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .i_result(i_result), .i_result_ready(i_result_ready),
    .o_busy(o_busy), .o_valid(o_valid), .o_sign(o_sign), .o_bcd(o_bcd),
    .o_ndigits(o_ndigits), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Decimal reference built by repeated division.
  function automatic vec_t model(input logic [31:0] r);
    vec_t        v;
    logic [31:0] m;
    v.res = r;
    v.sgn = r[31];
    m     = r[31] ? (32'd0 - r) : r;
    if (m == 0) v.sgn = 1'b0;
    v.bcd = '0;
    v.nd  = 4'd1;
    for (int i = 0; i < DIGITS; i++) begin
      v.bcd[4*i +: 4] = 4'(m % 10);
      if (m != 0 && i > 0) v.nd = 4'(i + 1);
      m = m / 10;
    end
    return v;
  endfunction

  task automatic push_exp(input vec_t v);
    vec_t e;
    e = v;
`ifdef M3_LEADING_ZERO_BLANK_EN
    for (int i = 1; i < DIGITS; i++) if (i >= int'(e.nd)) e.bcd[4*i +: 4] = 4'hF;
`endif
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (o_valid && !valid_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sign", {63'd0, o_sign}, {63'd0, mon_e.sgn});
        chk("bcd", {24'd0, o_bcd}, {24'd0, mon_e.bcd});
        chk("ndigits", {60'd0, o_ndigits}, {60'd0, mon_e.nd});
      end
    end
    valid_prev <= o_valid;
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, {63'd0, o_busy}, 64'd0);
    chk({tag, "_valid"}, {63'd0, o_valid}, 64'd0);
    chk({tag, "_sign"}, {63'd0, o_sign}, 64'd0);
    chk({tag, "_bcd"}, {24'd0, o_bcd}, 64'd0);
    chk({tag, "_nd"}, {60'd0, o_ndigits}, 64'd0);
    chk({tag, "_overrun"}, {63'd0, o_overrun}, 64'd0);
  endtask

  // Called at the negedge right after capture edge E; raise_k>0 injects a second rising ready after edge E+raise_k.
  task automatic track(input int raise_k);
    int first;
    chk("busy_after_capture", {63'd0, o_busy}, 64'd1);
    chk("valid_after_capture", {63'd0, o_valid}, 64'd0);
    if (raise_k == 0) i_result = $urandom;
    first = 0;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(negedge clk);
      if (raise_k > 0 && k == raise_k - 5) i_result_ready = 1'b0;
      if (raise_k > 0 && k == raise_k) begin
        i_result_ready = 1'b1;
        i_result       = 32'd99;
      end
      if (raise_k > 0 && k == raise_k + 1) chk("overrun_pulse", {63'd0, o_overrun}, 64'd1);
      if (raise_k > 0 && k == raise_k + 2) chk("overrun_single", {63'd0, o_overrun}, 64'd0);
      if (o_valid && first == 0) first = k;
    end
    chk("latency", 64'(first), 64'(LAT));
    chk("valid_held", {63'd0, o_valid}, 64'd1);
    chk("busy_done", {63'd0, o_busy}, 64'd0);
    i_result_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic conv(input vec_t v, input int raise_k);
    push_exp(v);
    i_result       = v.res;
    i_result_ready = 1'b1;
    @(negedge clk);
    track(raise_k);
  endtask

  vec_t tbl[8];
  vec_t tmp;

  initial begin
    tbl[0] = '{32'd11,         1'b0, 40'h0000000011, 4'd2};
    tbl[1] = '{32'hFFFFFFFA,   1'b1, 40'h0000000006, 4'd1};
    tbl[2] = '{32'd0,          1'b0, 40'h0000000000, 4'd1};
    tbl[3] = '{32'h80000000,   1'b1, 40'h2147483648, 4'd10};
    tbl[4] = '{32'h7FFFFFFF,   1'b0, 40'h2147483647, 4'd10};
    tbl[5] = '{32'd1000000000, 1'b0, 40'h1000000000, 4'd10};
    tbl[6] = '{32'hFFFFFFFF,   1'b1, 40'h0000000001, 4'd1};
    tbl[7] = '{32'd12345,      1'b0, 40'h0000012345, 4'd5};

    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) conv(tbl[i], 0);
    for (int i = 0; i < 4; i++) conv(model($urandom), 0);

    // Second rising ready mid-shift: ignored, result stays 11, then 99 converts normally.
    conv(tbl[0], 9);
    conv(model(32'd99), 0);
    // Second rising ready on the finishing edge: ignored, DONE holds.
    conv(tbl[0], 32);

    // Reset mid-conversion, with ready held high across release.
    push_exp(tbl[0]);
    i_result       = 32'd11;
    i_result_ready = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 14; k++) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("abort");
    tmp = sb.pop_back();
    i_result = 32'hFFFFCFC7;
    push_exp('{32'hFFFFCFC7, 1'b1, 40'h0000012345, 4'd5});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    track(0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
